// File: rtl/ovl_memory_sync_model_if.sv
// Read/write request and response bundle between a memory requester and the responder.
interface ovl_memory_sync_model_if #(
    parameter int unsigned data_width = 1,
    parameter int unsigned addr_width = 1
) ();
    logic                  enable;
    logic [addr_width-1:0] start_addr;
    logic [addr_width-1:0] end_addr;
    logic                  ren;
    logic [addr_width-1:0] raddr;
    logic                  wen;
    logic [addr_width-1:0] waddr;
    logic [data_width-1:0] wdata;
    logic [data_width-1:0] rdata;
    logic                  rvalid;
    logic [2:0]            status;

    // Requester side: issues accesses and the window, observes responses.
    modport master (
        output enable, start_addr, end_addr, ren, raddr, wen, waddr, wdata,
        input  rdata, rvalid, status
    );

    // Memory side: accepts accesses and returns responses.
    modport slave (
        input  enable, start_addr, end_addr, ren, raddr, wen, waddr, wdata,
        output rdata, rvalid, status
    );
endinterface

// File: rtl/ovl_memory_sync_model.sv
// Known-good synchronous memory responder with fixed read latency and
// address-window, uninitialised-read and same-cycle conflict reporting.
module ovl_memory_sync_model #(
    parameter int unsigned data_width   = 1,
    parameter int unsigned addr_width   = 1,
    parameter int unsigned mem_size     = 2,
    parameter int unsigned read_latency = 1,
    parameter int unsigned pass_thru    = 0
) (
    input logic                    clock,
    input logic                    reset,
    ovl_memory_sync_model_if.slave bus
);
    localparam bit          LAT_OK = (read_latency >= 1) && (read_latency <= 4);
    localparam int unsigned LAT    = LAT_OK ? read_latency : 1;
    localparam int unsigned IDX_W  = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam int unsigned CMP_W  = (addr_width > 32) ? addr_width : 32;
    localparam bit          PASS   = (pass_thru != 0);

    // An out-of-range latency is flagged at elaboration; the block falls back to one stage.
    generate
        if (!LAT_OK) begin : g_bad_latency
            $warning("ovl_memory_sync_model: read_latency %0d outside 1..4, using 1", read_latency);
        end
    endgenerate

    // One read-pipeline stage: validity, returned word and the read-side error flags.
    typedef struct packed {
        logic                  valid;
        logic                  addr_err;
        logic                  uninit;
        logic [data_width-1:0] data;
    } rd_stage_t;

    logic [data_width-1:0] mem [mem_size];
    logic [mem_size-1:0]   written;
    rd_stage_t             pipe [LAT];
    rd_stage_t             stage_in;

    logic             rd_acc;
    logic             wr_acc;
    logic             rd_in;
    logic             wr_in;
    logic             same_addr;
    logic             wr_commit;
    logic             wr_addr_err;
    logic             wr_conflict;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Legal when inside a non-inverted window and below mem_size; no aliasing.
    function automatic logic in_window(
        input logic [addr_width-1:0] a,
        input logic [addr_width-1:0] lo,
        input logic [addr_width-1:0] hi
    );
        return (lo <= hi) && (a >= lo) && (a <= hi) && (CMP_W'(a) < CMP_W'(mem_size));
    endfunction

    // Accept, range and collision decode for the current cycle.
    always_comb begin
        rd_acc      = bus.enable & bus.ren;
        wr_acc      = bus.enable & bus.wen;
        rd_in       = in_window(bus.raddr, bus.start_addr, bus.end_addr);
        wr_in       = in_window(bus.waddr, bus.start_addr, bus.end_addr);
        rd_idx      = IDX_W'(bus.raddr);
        wr_idx      = IDX_W'(bus.waddr);
        same_addr   = rd_acc && wr_acc && rd_in && wr_in && (bus.raddr == bus.waddr);
        wr_commit   = wr_acc && wr_in;
        wr_addr_err = wr_acc && !wr_in;
        wr_conflict = same_addr && !PASS;
    end

    // Build the pipeline entry for an accepted read; errored reads return zero.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = rd_acc;
        if (rd_acc) begin
            if (!rd_in) begin
                stage_in.addr_err = 1'b1;
            end else if (same_addr && PASS) begin
                stage_in.data = bus.wdata;
            end else if (written[rd_idx]) begin
                stage_in.data = mem[rd_idx];
            end else begin
                stage_in.uninit = 1'b1;
            end
        end
    end

    // Storage array; contents survive reset and are masked by the written bits.
    always_ff @(posedge clock) begin
        if (wr_commit) begin
            mem[wr_idx] <= bus.wdata;
        end
    end

    // Per-word written flags, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            written <= '0;
        end else if (wr_commit) begin
            written[wr_idx] <= 1'b1;
        end
    end

    // Read latency shift register; reset discards reads in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Registered response: read result plus write-side errors of this edge, ORed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.status <= 3'b000;
        end else begin
            bus.rvalid <= pipe[LAT-1].valid;
            bus.rdata  <= pipe[LAT-1].data;
            bus.status <= {wr_conflict, pipe[LAT-1].uninit, wr_addr_err | pipe[LAT-1].addr_err};
        end
    end
endmodule

// File: tb/tb_ovl_memory_sync_model.sv
// Directed bench: cycle table on a latency-2 responder, hand sequences on a
// latency-4 pass-through responder for collision and mid-flight reset.
module tb_ovl_memory_sync_model;
    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       en    = 1'b0;
    logic       ren   = 1'b0;
    logic       wen   = 1'b0;
    logic [2:0] raddr = '0;
    logic [2:0] waddr = '0;
    logic [2:0] sa    = '0;
    logic [2:0] ea    = 3'd5;
    logic [3:0] wdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ovl_memory_sync_model_if #(.data_width(4), .addr_width(3)) if_a ();
    ovl_memory_sync_model_if #(.data_width(4), .addr_width(3)) if_b ();

    assign if_a.enable = en;   assign if_b.enable = en;
    assign if_a.ren = ren;     assign if_b.ren = ren;
    assign if_a.raddr = raddr; assign if_b.raddr = raddr;
    assign if_a.wen = wen;     assign if_b.wen = wen;
    assign if_a.waddr = waddr; assign if_b.waddr = waddr;
    assign if_a.wdata = wdata; assign if_b.wdata = wdata;
    assign if_a.start_addr = sa; assign if_b.start_addr = sa;
    assign if_a.end_addr = ea;   assign if_b.end_addr = ea;

    ovl_memory_sync_model #(
        .data_width(4), .addr_width(3), .mem_size(6), .read_latency(2), .pass_thru(0)
    ) dut_a (
        .clock(clock), .reset(reset), .bus(if_a)
    );

    ovl_memory_sync_model #(
        .data_width(4), .addr_width(3), .mem_size(6), .read_latency(4), .pass_thru(1)
    ) dut_b (
        .clock(clock), .reset(reset), .bus(if_b)
    );

    typedef struct {
        logic       ren;
        logic [2:0] raddr;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wdata;
        logic       en;
        logic [2:0] sa;
        logic [2:0] ea;
        logic       xv;
        logic [3:0] xd;
        logic [2:0] xs;
    } vec_t;

    localparam int NV = 44;
    vec_t tbl [NV];

    function automatic vec_t mk(input int r, input int ra, input int w, input int wa, input int wd,
                                input int e, input int s, input int en_a,
                                input int xv, input int xd, input int xs);
        vec_t v;
        v.ren = 1'(r);   v.raddr = 3'(ra);
        v.wen = 1'(w);   v.waddr = 3'(wa);  v.wdata = 4'(wd);
        v.en  = 1'(e);   v.sa = 3'(s);      v.ea = 3'(en_a);
        v.xv  = 1'(xv);  v.xd = 4'(xd);     v.xs = 3'(xs);
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] ra, input logic w, input logic [2:0] wa,
                         input logic [3:0] wd, input logic e, input logic [2:0] s, input logic [2:0] en_a);
        ren = r; raddr = ra; wen = w; waddr = wa; wdata = wd; en = e; sa = s; ea = en_a;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd0, 3'd5);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // ren,raddr, wen,waddr,wdata, en,sa,ea, exp rvalid,rdata,status
        tbl[0]  = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[1]  = mk(0,0, 1,1,5,    1,0,5, 0,0,0);
        tbl[2]  = mk(1,1, 0,0,0,    1,0,5, 0,0,0);
        tbl[3]  = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[4]  = mk(0,0, 0,0,0,    1,0,5, 1,5,0);
        tbl[5]  = mk(1,2, 0,0,0,    1,0,5, 0,0,0);
        tbl[6]  = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[7]  = mk(0,0, 0,0,0,    1,0,5, 1,0,2);
        tbl[8]  = mk(0,0, 1,3,7,    1,1,2, 0,0,1);
        tbl[9]  = mk(1,0, 0,0,0,    1,1,2, 0,0,0);
        tbl[10] = mk(0,0, 0,0,0,    1,1,2, 0,0,0);
        tbl[11] = mk(0,0, 0,0,0,    1,1,2, 1,0,1);
        tbl[12] = mk(1,3, 0,0,0,    1,0,5, 0,0,0);
        tbl[13] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[14] = mk(0,0, 0,0,0,    1,0,5, 1,0,2);
        tbl[15] = mk(0,0, 1,6,9,    1,0,7, 0,0,1);
        tbl[16] = mk(1,6, 0,0,0,    1,0,7, 0,0,0);
        tbl[17] = mk(0,0, 0,0,0,    1,0,7, 0,0,0);
        tbl[18] = mk(0,0, 0,0,0,    1,0,7, 1,0,1);
        tbl[19] = mk(1,4, 1,4,3,    1,4,2, 0,0,1);
        tbl[20] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[21] = mk(0,0, 0,0,0,    1,0,5, 1,0,1);
        tbl[22] = mk(0,0, 1,0,10,   1,0,5, 0,0,0);
        tbl[23] = mk(1,0, 1,0,11,   1,0,5, 0,0,4);
        tbl[24] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[25] = mk(0,0, 0,0,0,    1,0,5, 1,10,0);
        tbl[26] = mk(1,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[27] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[28] = mk(0,0, 0,0,0,    1,0,5, 1,11,0);
        tbl[29] = mk(0,0, 1,2,12,   1,0,5, 0,0,0);
        tbl[30] = mk(0,0, 1,3,13,   1,0,5, 0,0,0);
        tbl[31] = mk(1,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[32] = mk(1,1, 0,0,0,    1,0,5, 0,0,0);
        tbl[33] = mk(1,2, 0,0,0,    0,0,5, 1,11,0);
        tbl[34] = mk(1,3, 0,0,0,    1,0,5, 1,5,0);
        tbl[35] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[36] = mk(0,0, 0,0,0,    1,0,5, 1,13,0);
        tbl[37] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[38] = mk(0,0, 1,7,1,    0,0,5, 0,0,0);
        tbl[39] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[40] = mk(1,5, 0,0,0,    1,0,5, 0,0,0);
        tbl[41] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);
        tbl[42] = mk(0,0, 1,7,1,    1,0,5, 1,0,3);
        tbl[43] = mk(0,0, 0,0,0,    1,0,5, 0,0,0);

        // Asynchronous reset at start.
        #1 reset = 1'b0;
        #1;
        chk("reset.a.rvalid", 0, 8'(if_a.rvalid), 8'h0);
        chk("reset.a.rdata",  0, 8'(if_a.rdata),  8'h0);
        chk("reset.a.status", 0, 8'(if_a.status), 8'h0);
        chk("reset.b.rvalid", 0, 8'(if_b.rvalid), 8'h0);
        chk("reset.b.rdata",  0, 8'(if_b.rdata),  8'h0);
        chk("reset.b.status", 0, 8'(if_b.status), 8'h0);
        idle();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Cycle table against the latency-2, old-data responder.
        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].ren, tbl[k].raddr, tbl[k].wen, tbl[k].waddr, tbl[k].wdata,
                  tbl[k].en, tbl[k].sa, tbl[k].ea);
            step();
            chk("tbl.rvalid", k, 8'(if_a.rvalid), 8'(tbl[k].xv));
            chk("tbl.rdata",  k, 8'(if_a.rdata),  8'(tbl[k].xd));
            chk("tbl.status", k, 8'(if_a.status), 8'(tbl[k].xs));
        end
        idle();
        for (int i = 0; i < 6; i++) step();

        // Pass-through collision on the latency-4 responder.
        drive(1'b0, 3'd0, 1'b1, 3'd0, 4'hA, 1'b1, 3'd0, 3'd5);
        step();
        chk("coll.b.status_wr", 0, 8'(if_b.status), 8'h0);
        drive(1'b1, 3'd0, 1'b1, 3'd0, 4'hB, 1'b1, 3'd0, 3'd5);
        step();
        chk("coll.b.status_rw", 0, 8'(if_b.status), 8'h0);
        chk("coll.a.status_rw", 0, 8'(if_a.status), 8'h4);
        idle();
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("coll.b.rvalid", i, 8'(if_b.rvalid), (i == 4) ? 8'h1 : 8'h0);
            chk("coll.b.status", i, 8'(if_b.status), 8'h0);
            if (i == 4) chk("coll.b.rdata", i, 8'(if_b.rdata), 8'hB);
            if (i == 2) chk("coll.a.rdata", i, 8'(if_a.rdata), 8'hA);
        end

        // Reset asserted between clocks 1 and 2 of a latency-4 read.
        drive(1'b0, 3'd0, 1'b1, 3'd1, 4'h6, 1'b1, 3'd0, 3'd5);
        step();
        drive(1'b1, 3'd1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd0, 3'd5);
        step();
        drive(1'b0, 3'd0, 1'b1, 3'd7, 4'h0, 1'b1, 3'd0, 3'd5);
        step();
        chk("rst.b.pre_status", 0, 8'(if_b.status), 8'h1);
        idle();
        #2 reset = 1'b0;
        #1;
        chk("rst.b.rvalid", 0, 8'(if_b.rvalid), 8'h0);
        chk("rst.b.rdata",  0, 8'(if_b.rdata),  8'h0);
        chk("rst.b.status", 0, 8'(if_b.status), 8'h0);
        chk("rst.a.status", 0, 8'(if_a.status), 8'h0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst.b.no_rvalid", i, 8'(if_b.rvalid), 8'h0);
            chk("rst.a.no_rvalid", i, 8'(if_a.rvalid), 8'h0);
        end
        drive(1'b1, 3'd1, 1'b0, 3'd0, 4'h0, 1'b1, 3'd0, 3'd5);
        step();
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rst.b.rvalid_after", i, 8'(if_b.rvalid), (i == 4) ? 8'h1 : 8'h0);
            if (i == 4) begin
                chk("rst.b.rdata_after",  i, 8'(if_b.rdata),  8'h0);
                chk("rst.b.status_after", i, 8'(if_b.status), 8'h2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ovl_memory_sync_model.md
# ovl_memory_sync_model

Synchronous memory responder that drives the read/write interface monitored by the synchronous memory checker. It stores write data, returns read data after a fixed latency, and flags out-of-window accesses, uninitialised reads and same-cycle address conflicts. It sits in checker self-test benches as the known-good device under check, and can be switched into fault modes to exercise checker firings.

## Interface
- data_width, 1, width of each memory word
- addr_width, 1, address width
- mem_size, 2, number of words; legal addresses are 0..mem_size-1
- read_latency, 1, clocks from accepted read to rdata/rvalid; legal range 1..4
- pass_thru, 0, 1: same-cycle read of the address being written returns wdata; 0: returns old contents
- clock  input  1  single clock, rising edge active
- reset  input  1  asynchronous active-low reset
- enable  input  1  gates acceptance of new ren/wen; in-flight reads still complete
- start_addr  input  addr_width  lowest legal address of the access window
- end_addr  input  addr_width  highest legal address of the access window
- ren  input  1  read request
- raddr  input  addr_width  read address
- wen  input  1  write request
- waddr  input  addr_width  write address
- wdata  input  data_width  write data
- rdata  output  data_width  read data, valid only while rvalid=1
- rvalid  output  1  one-cycle pulse per accepted read
- status  output  3  bit0 address error, bit1 uninitialised read, bit2 conflict; one-cycle pulses

## Operation
- Storage: array of mem_size words plus one written bit per word.
- Accepted read: ren=1 and enable=1 at a rising edge. Accepted write: wen=1 and enable=1.
- In range: start_addr <= addr <= end_addr and addr < mem_size. If start_addr > end_addr, every address is out of range.
- Write in range: word and its written bit update at the edge. Write out of range: dropped, status[0] pulses.
- Read in range and written: the returned data is the array word. Read in range and unwritten: rdata=0, status[1] pulses. Read out of range: rdata=0, status[0] pulses.
- Same-cycle read and write to the same in-range address:
  - pass_thru=1: returns wdata and counts as initialised; no conflict.
  - pass_thru=0: returns previous contents (0 plus status[1] if unwritten); status[2] pulses.
- Read pipeline: a shift register of read_latency stages carries valid, data and read-error flags. Back-to-back reads are accepted every cycle.
- Write-side errors (status[0] from a write, status[2]) pulse the cycle after the write edge. Read-side errors pulse together with that read's rvalid. When both coincide, the bits are ORed.
- enable=0 blocks new accesses and error reporting for them. The pipeline keeps shifting.

## Timing
- Reset (reset=0, asynchronous): rdata=0, rvalid=0, status=0. All pipeline stages are cleared and all written bits are cleared. Array contents are not cleared; they are unreadable until rewritten.
- Reset deasserted mid-burst: reads in flight at assertion are discarded and never produce rvalid.
- Read accepted at edge N: rvalid=1 and rdata valid after edge N+read_latency, for exactly one cycle.
- A write at edge N is visible to a read accepted at edge N+1, or at edge N when pass_thru=1.
- Address wrap-around: none. addr >= mem_size is an address error even if the index aliases within the array.
- read_latency outside 1..4 is a parameter error. It is reported by the init mechanism at time 0, and the block behaves as read_latency=1.

## Test plan
- Reset then single access: read_latency=2, write 0x5 to addr 1, read addr 1 next cycle -> rvalid and rdata=0x5 exactly 2 clocks after the read edge; status=0.
- Uninitialised read: mem_size=4, window 0..3, after reset read addr 2 -> rdata=0, status=3'b010 with rvalid.
- Window and range errors: window 1..2, write addr 3 then read addr 0 -> status[0] one cycle after the write; status[0] with the read's rvalid; rdata=0; addr 3 still reads unwritten afterwards.
- Collision: write 0xA to addr 0, then a same-cycle read plus write of 0xB to addr 0 -> pass_thru=0 gives rdata=0xA and status[2]; pass_thru=1 gives rdata=0xB and no status.
- Streaming with enable: reads every cycle to addrs 0..3 with enable dropped for cycle 2 -> three rvalid pulses, the gap aligned to cycle 2 plus latency, data in order.
- Async reset mid-flight: read_latency=4, issue a read, assert reset between clocks 1 and 2 -> outputs drop immediately, no rvalid after release, and a later read of the written address reports uninitialised.
